// File: rtl/clk_period_meter_pkg.sv
// Purpose: shared FSM state encoding and default parameter constants for
//          the clock period meter.
// Ports:   none (package).
package clk_period_meter_pkg;

    localparam int unsigned DEF_WIDTH       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_LOCK_COUNT  = 4;
    localparam int unsigned DEF_TOL         = 1;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } meter_state_e;

endpackage

// File: rtl/clk_period_meter_if.sv
// Purpose: measurement result bundle of the clock period meter.
// Signals: period, high_time (WIDTH) - last measured interval / high part
//          meas_valid - one-cycle update strobe
//          locked     - period stable over several windows
//          timeout    - no rising edge for 2^WIDTH-1 cycles (sticky)
// Modports: master drives the results, slave observes them.
interface clk_period_meter_if
    import clk_period_meter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output period,
        output high_time,
        output meas_valid,
        output locked,
        output timeout
    );

    modport slave (
        input period,
        input high_time,
        input meas_valid,
        input locked,
        input timeout
    );

endinterface

// File: rtl/clk_edge_sync.sv
// Purpose: bring an asynchronous level into the clk domain and flag its
//          edges with single-cycle pulses.
// Ports:   clk, reset (async, active-high)
//          d    - asynchronous input level
//          rise - one-cycle pulse on a synchronized 0->1 transition
//          fall - one-cycle pulse on a synchronized 1->0 transition
module clk_edge_sync
    import clk_period_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Synchronizer chain followed by the one-flop edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_prev <= w_sync;
        end
    end

    assign rise = w_sync & ~r_prev;
    assign fall = ~w_sync & r_prev;

endmodule

// File: rtl/clk_period_meter.sv
// Purpose: measure the period and high time of an asynchronous clock in
//          units of clk cycles, and report lock and loss of the input.
// Ports:   clk, reset (async, active-high)
//          clk_in - clock under measurement (asynchronous to clk)
//          mon    - result bundle (period, high_time, meas_valid, locked,
//                   timeout), all driven from registers
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int unsigned TOL         = DEF_TOL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_in,
    clk_period_meter_if.master    mon
);

    localparam int unsigned      MC_W    = $clog2(LOCK_COUNT);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [MC_W-1:0]  MC_TOP  = MC_W'(LOCK_COUNT - 1);
    localparam logic [WIDTH-1:0] TOL_W   = WIDTH'(TOL);

    meter_state_e     r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_hcap, w_hcap_nxt;
    logic             r_fall_seen, w_fall_seen_nxt;
    logic [MC_W-1:0]  r_mc, w_mc_nxt;
    logic [WIDTH-1:0] r_period, w_period_nxt;
    logic [WIDTH-1:0] r_high_time, w_high_time_nxt;
    logic             r_meas_valid, w_meas_valid_nxt;
    logic             r_locked, w_locked_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic             w_rise;
    logic             w_fall;
    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_diff;
    logic             w_match;
    logic [MC_W-1:0]  w_mc_inc;

    clk_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .reset (reset),
        .d     (clk_in),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    // Saturating count+1: a rise at the last count still reports 2^WIDTH-1.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + WIDTH'(1);
    assign w_diff    = (w_cnt_inc >= r_period) ? (w_cnt_inc - r_period)
                                               : (r_period - w_cnt_inc);
    assign w_match   = (w_diff <= TOL_W);
    assign w_mc_inc  = (r_mc == MC_TOP) ? r_mc : r_mc + MC_W'(1);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= SEEK;
            r_cnt        <= '0;
            r_hcap       <= '0;
            r_fall_seen  <= 1'b0;
            r_mc         <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hcap       <= w_hcap_nxt;
            r_fall_seen  <= w_fall_seen_nxt;
            r_mc         <= w_mc_nxt;
            r_period     <= w_period_nxt;
            r_high_time  <= w_high_time_nxt;
            r_meas_valid <= w_meas_valid_nxt;
            r_locked     <= w_locked_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_hcap_nxt       = r_hcap;
        w_fall_seen_nxt  = r_fall_seen;
        w_mc_nxt         = r_mc;
        w_period_nxt     = r_period;
        w_high_time_nxt  = r_high_time;
        w_meas_valid_nxt = 1'b0;
        w_locked_nxt     = r_locked;
        w_timeout_nxt    = r_timeout;

        case (r_state)
            // A rise only opens the first window; nothing is reported.
            SEEK, LOST: begin
                if (w_rise) begin
                    w_state_nxt     = MEASURE;
                    w_cnt_nxt       = '0;
                    w_fall_seen_nxt = 1'b0;
                    w_timeout_nxt   = 1'b0;
                end
            end

            MEASURE: begin
                if (w_rise) begin
                    // Rise takes priority over counter saturation.
                    w_period_nxt     = w_cnt_inc;
                    w_high_time_nxt  = r_fall_seen ? r_hcap : w_cnt_inc;
                    w_meas_valid_nxt = 1'b1;
                    w_cnt_nxt        = '0;
                    w_fall_seen_nxt  = 1'b0;
                    if (w_match) begin
                        w_mc_nxt     = w_mc_inc;
                        w_locked_nxt = (w_mc_inc == MC_TOP);
                    end else begin
                        w_mc_nxt     = '0;
                        w_locked_nxt = 1'b0;
                    end
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt   = LOST;
                    w_timeout_nxt = 1'b1;
                    w_locked_nxt  = 1'b0;
                    w_mc_nxt      = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_fall) begin
                        w_hcap_nxt      = w_cnt_inc;
                        w_fall_seen_nxt = 1'b1;
                    end
                end
            end

            default: w_state_nxt = SEEK;
        endcase
    end

    assign mon.period     = r_period;
    assign mon.high_time  = r_high_time;
    assign mon.meas_valid = r_meas_valid;
    assign mon.locked     = r_locked;
    assign mon.timeout    = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Purpose: directed self-checking bench for clk_period_meter (WIDTH=8).
// Ports:   none (top-level bench).
module tb_clk_period_meter;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset;
    logic clk_in;

    clk_period_meter_if #(.WIDTH(W)) u_if ();

    clk_period_meter #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .LOCK_COUNT  (4),
        .TOL         (1)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .clk_in (clk_in),
        .mon    (u_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] per;
        logic [W-1:0] hi;
        logic         lk;
        logic         to;
    } meas_t;

    meas_t q[$];
    logic  saw_to;
    int    n_checks = 0;
    int    n_fail   = 0;

    // Expected results for the first run (hand-computed, one per closed window).
    int exp1_per[16] = '{6,6,6,6,6,6,6,8,6,6,6,6,7,6,6,6};
    int exp1_hi [16] = '{3,3,3,3,3,2,2,4,3,3,3,3,4,3,3,3};
    int exp1_lk [16] = '{0,0,0,1,1,1,1,0,0,0,0,1,1,1,0,0};
    // Expected results after the mid-window reset.
    int exp2_per[3]  = '{6,10,255};
    int exp2_hi [3]  = '{3,5,100};
    int exp2_lk [3]  = '{0,0,0};

    // Collect every measurement strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (u_if.meas_valid)
                q.push_back('{per: u_if.period, hi: u_if.high_time,
                              lk: u_if.locked, to: u_if.timeout});
            if (u_if.timeout)
                saw_to = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int h, input int l);
        clk_in = 1'b1;
        tick(h);
        clk_in = 1'b0;
        tick(l);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".period"},     32'(u_if.period),     32'd0);
        chk({tag, ".high_time"},  32'(u_if.high_time),  32'd0);
        chk({tag, ".meas_valid"}, 32'(u_if.meas_valid), 32'd0);
        chk({tag, ".locked"},     32'(u_if.locked),     32'd0);
        chk({tag, ".timeout"},    32'(u_if.timeout),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        clk_in = 1'b0;
        saw_to = 1'b0;
        tick(3);
        chk_outputs_zero("reset");
        reset = 1'b0;
        tick(2);

        // Steady 3/3, duty change 2/4, a window of 8, relock, a window of 7.
        for (int i = 0; i < 5; i++) pulse(3, 3);
        for (int i = 0; i < 2; i++) pulse(2, 4);
        pulse(4, 4);
        for (int i = 0; i < 4; i++) pulse(3, 3);
        pulse(4, 3);
        pulse(3, 3);

        // Hold clk_in low well past 255 counts.
        clk_in = 1'b1;
        tick(3);
        clk_in = 1'b0;
        tick(300);
        chk("lost.timeout",   32'(u_if.timeout),   32'd1);
        chk("lost.locked",    32'(u_if.locked),    32'd0);
        chk("lost.period",    32'(u_if.period),    32'd6);
        chk("lost.high_time", 32'(u_if.high_time), 32'd3);

        // First rise after loss only re-arms.
        pulse(3, 3);
        chk("rearm.timeout", 32'(u_if.timeout), 32'd0);
        chk("rearm.count",   32'(q.size()),     32'd14);
        pulse(3, 3);
        pulse(3, 3);
        tick(4);

        chk("run1.count", 32'(q.size()), 32'd16);
        for (int i = 0; i < 16 && i < q.size(); i++) begin
            chk($sformatf("run1[%0d].period", i),    32'(q[i].per), 32'(exp1_per[i]));
            chk($sformatf("run1[%0d].high_time", i), 32'(q[i].hi),  32'(exp1_hi[i]));
            chk($sformatf("run1[%0d].locked", i),    32'(q[i].lk),  32'(exp1_lk[i]));
            chk($sformatf("run1[%0d].timeout", i),   32'(q[i].to),  32'd0);
        end
        chk("run1.saw_timeout", 32'(saw_to), 32'd1);

        // Asynchronous reset in the middle of an open window.
        tick(2);
        reset = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        tick(2);
        reset = 1'b0;
        q.delete();
        saw_to = 1'b0;
        tick(2);

        // Re-arm, two normal windows, then a window ending exactly at count 255.
        pulse(3, 3);
        pulse(5, 5);
        pulse(100, 156);
        pulse(3, 3);
        tick(4);

        chk("run2.count", 32'(q.size()), 32'd3);
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            chk($sformatf("run2[%0d].period", i),    32'(q[i].per), 32'(exp2_per[i]));
            chk($sformatf("run2[%0d].high_time", i), 32'(q[i].hi),  32'(exp2_hi[i]));
            chk($sformatf("run2[%0d].locked", i),    32'(q[i].lk),  32'(exp2_lk[i]));
            chk($sformatf("run2[%0d].timeout", i),   32'(q[i].to),  32'd0);
        end
        chk("run2.timeout",     32'(u_if.timeout), 32'd0);
        chk("run2.saw_timeout", 32'(saw_to),       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter WIDTH, default 16: width of the cycle counter and of the period/high_time outputs.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops on clk_in (minimum 2).
REQ-003 Parameter LOCK_COUNT, default 4: consecutive matching periods required to assert locked (minimum 2).
REQ-004 Parameter TOL, default 1: allowed absolute period difference, in clk cycles, for two measurements to match.
REQ-005 clk  input  1  measurement clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 clk_in  input  1  divided/unknown clock under measurement, asynchronous to clk.
REQ-008 period  output  WIDTH  last measured rising-to-rising interval, in clk cycles.
REQ-009 high_time  output  WIDTH  clk cycles clk_in was high within that interval.
REQ-010 meas_valid  output  1  one-cycle strobe: period/high_time updated this cycle.
REQ-011 locked  output  1  period stable for LOCK_COUNT consecutive measurements.
REQ-012 timeout  output  1  no rising edge seen within 2^WIDTH-1 cycles; sticky until next rising edge.

Function
REQ-013 clk_in SHALL pass through SYNC_STAGES flops, then a one-flop edge detector producing rise/fall pulses of one clk cycle.
REQ-014 FSM states SHALL be SEEK (wait first rise, no counting), MEASURE (counting), and LOST (timed out, waiting for a rise).
REQ-015 SEEK→MEASURE on rise: cnt←0, no meas_valid (first edge only opens the window).
REQ-016 In MEASURE, each cycle without rise SHALL increment cnt; on fall, hcap←cnt+1.
REQ-017 In MEASURE, on rise: period←cnt+1, high_time←hcap, meas_valid=1 the following cycle, cnt←0; i.e., outputs appear 1 cycle after the synchronized rise.
REQ-018 For clk_in high for H and low for L clk cycles (steady), period SHALL equal H+L and high_time SHALL equal H.
REQ-019 Match: |new period − previous period| ≤ TOL; match_cnt increments on match (saturating at LOCK_COUNT−1), otherwise resets to 0.
REQ-020 locked SHALL assert in the meas_valid cycle at which match_cnt reaches LOCK_COUNT−1, and SHALL deassert in the meas_valid cycle of the first mismatch.
REQ-021 If cnt reaches 2^WIDTH−1 in MEASURE with no rise: go to LOST, timeout=1, locked=0, match_cnt=0; period/high_time hold their values; no meas_valid.
REQ-022 LOST→MEASURE on rise: timeout←0, cnt←0, no meas_valid (equivalent to SEEK).
REQ-023 Rise and cnt saturation in the same cycle: rise SHALL win (valid measurement, period=2^WIDTH−1... saturated value 2^WIDTH−1, no timeout).
REQ-024 Rise and fall SHALL never be simultaneous after synchronization; if clk_in has no fall in a window, high_time SHALL report period.
REQ-025 Period arithmetic SHALL be unsigned WIDTH bits; the TOL compare uses the absolute difference without overflow.

Reset
REQ-026 On reset: state=SEEK, cnt=0, hcap=0, match_cnt=0, period=0, high_time=0, meas_valid=0, locked=0, timeout=0, sync/edge flops=0.
REQ-027 Reset asserted mid-measurement SHALL discard the open window; after release, the first rise only re-arms (REQ-015).

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (SEEK, MEASURE, LOST) and the default parameter constants.
REQ-029 Synchronizer plus edge detector SHALL be the sub-module clk_edge_sync (ports clk, reset, d, rise, fall); all other logic SHALL be in clk_period_meter.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 clk_in from clk_div N=3 (3 high/3 low): period=6, high_time=3 on every meas_valid; locked=1 at the 4th meas_valid.
REQ-032 Duty change to 2 high/4 low after lock: period=6, high_time=2, locked stays 1.
REQ-033 Locked at period 6, then one window of 8: locked→0 in that meas_valid cycle; relocks after 4 matching windows at 6; a window of 7 (TOL=1) does not drop lock.
REQ-034 WIDTH=8, clk_in held low after lock: timeout=1 and locked=0 at cnt=255; period holds 6; next rise clears timeout without meas_valid; valid resumes on the following rise.
REQ-035 Reset pulsed mid-window: all outputs 0 immediately (asynchronous); first post-reset rise gives no meas_valid; second gives the correct period.
REQ-036 Rise coincident with cnt=2^WIDTH−1 (WIDTH=8): meas_valid=1, period=255, timeout stays 0.
